// File: rtl/shift_sequencer_if.sv
// Command/result handshake bundle for shift_sequencer.
// Master drives the command and accepts the result; slave is the shift unit.
interface shift_sequencer_if #(
    parameter int unsigned Nbits = 32
);
    localparam int unsigned Abits = $clog2(Nbits);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [Abits-1:0] amt;
    logic [Nbits-1:0] In;
    logic             out_valid;
    logic             out_ready;
    logic [Nbits-1:0] Out;

    modport master (
        output in_valid, op, amt, In, out_ready,
        input  in_ready, out_valid, Out
    );

    modport slave (
        input  in_valid, op, amt, In, out_ready,
        output in_ready, out_valid, Out
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle variable-amount shifter: one step of 3 (or 1 for the remainder) per clock.
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
module shift_sequencer #(
    parameter int unsigned Nbits = 32
) (
    input logic              clk,
    input logic              reset_n,
    shift_sequencer_if.slave bus
);
    localparam int unsigned Abits = $clog2(Nbits);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [Nbits-1:0] r_work;
    logic [Nbits-1:0] r_out;
    logic [Nbits-1:0] w_step;
    logic [Abits-1:0] r_cnt;
    logic [Abits-1:0] w_cnt_next;
    logic [1:0]       r_op;
    logic             w_big;
    logic             w_accept;

    assign w_accept   = (r_state == StIdle) && bus.in_valid;
    assign w_big      = (r_cnt >= Abits'(3));
    assign w_cnt_next = w_big ? (r_cnt - Abits'(3)) : (r_cnt - Abits'(1));

    // One shift step: by 3 while at least 3 remain, else by 1.
    always_comb begin
        w_step = r_work;
        case (r_op)
            2'b00: w_step = w_big ? {r_work[Nbits-4:0], 3'b000}
                                  : {r_work[Nbits-2:0], 1'b0};
            2'b01: w_step = w_big ? {3'b000, r_work[Nbits-1:3]}
                                  : {1'b0, r_work[Nbits-1:1]};
            2'b10: w_step = w_big ? {{3{r_work[Nbits-1]}}, r_work[Nbits-1:3]}
                                  : {r_work[Nbits-1], r_work[Nbits-1:1]};
            default: w_step = w_big ? {r_work[2:0], r_work[Nbits-1:3]}
                                    : {r_work[0], r_work[Nbits-1:1]};
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_state_next = (bus.amt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (w_cnt_next == '0) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Out is only written when a result completes, so it holds steady in IDLE and DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_work <= '0;
            r_out  <= '0;
            r_cnt  <= '0;
            r_op   <= '0;
        end else if (w_accept) begin
            r_work <= bus.In;
            r_op   <= bus.op;
            r_cnt  <= bus.amt;
            if (bus.amt == '0) begin
                r_out <= bus.In;
            end
        end else if (r_state == StShift) begin
            r_work <= w_step;
            r_cnt  <= w_cnt_next;
            if (w_cnt_next == '0) begin
                r_out <= w_step;
            end
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.Out       = r_out;
endmodule
